// File: rtl/y86_pipe_pkg.sv
// ---------------------------------------------------------------------------
// y86_pipe_pkg
// Shared definitions for the Y86-64 pipeline stage registers:
//   - field widths and status / instruction codes
//   - packed per-stage payload bundles and their flat widths (D_W..W_W)
//   - per-stage bubble images (status AOK, icode NOP, everything else idle)
//   - the stage action type and the bubble/stall resolution helper
// ---------------------------------------------------------------------------
package y86_pipe_pkg;

  // Field widths
  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;
  localparam int IFUN_W  = 4;
  localparam int REG_W   = 4;
  localparam int WORD_W  = 64;

  // Status codes
  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  // Instruction codes used by the stage registers themselves
  localparam logic [ICODE_W-1:0] ICODE_HALT = 4'h0;
  localparam logic [ICODE_W-1:0] ICODE_NOP  = 4'h1;

  // Register id meaning "no register"
  localparam logic [REG_W-1:0] REG_NONE = 4'hF;

  // Decode-stage bundle (output of fetch)
  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [IFUN_W-1:0]  ifun;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [WORD_W-1:0]  valc;
    logic [WORD_W-1:0]  valp;
  } d_bundle_t;

  // Execute-stage bundle (output of decode)
  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [IFUN_W-1:0]  ifun;
    logic [WORD_W-1:0]  valc;
    logic [WORD_W-1:0]  vala;
    logic [WORD_W-1:0]  valb;
    logic [REG_W-1:0]   dste;
    logic [REG_W-1:0]   dstm;
    logic [REG_W-1:0]   srca;
    logic [REG_W-1:0]   srcb;
  } e_bundle_t;

  // Memory-stage bundle (output of execute)
  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic               cnd;
    logic [WORD_W-1:0]  vale;
    logic [WORD_W-1:0]  vala;
    logic [REG_W-1:0]   dste;
    logic [REG_W-1:0]   dstm;
  } m_bundle_t;

  // Write-back bundle (output of memory)
  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [WORD_W-1:0]  vale;
    logic [WORD_W-1:0]  valm;
    logic [REG_W-1:0]   dste;
    logic [REG_W-1:0]   dstm;
  } w_bundle_t;

  // Flat payload widths fed to pipe_stage_reg
  localparam int D_W = $bits(d_bundle_t);
  localparam int E_W = $bits(e_bundle_t);
  localparam int M_W = $bits(m_bundle_t);
  localparam int W_W = $bits(w_bundle_t);

  // Bubble images. Downstream stages see REG_NONE destinations/sources so a
  // nop never creates a forwarding or write-back hazard.
  localparam d_bundle_t D_BUBBLE = '{
    stat: STAT_AOK, icode: ICODE_NOP, default: '0};
  localparam e_bundle_t E_BUBBLE = '{
    stat: STAT_AOK, icode: ICODE_NOP,
    dste: REG_NONE, dstm: REG_NONE, srca: REG_NONE, srcb: REG_NONE,
    default: '0};
  localparam m_bundle_t M_BUBBLE = '{
    stat: STAT_AOK, icode: ICODE_NOP,
    dste: REG_NONE, dstm: REG_NONE, default: '0};
  localparam w_bundle_t W_BUBBLE = '{
    stat: STAT_AOK, icode: ICODE_NOP,
    dste: REG_NONE, dstm: REG_NONE, default: '0};

  // What a stage register does on the coming edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_act_e;

  // Resolve the requested bubble/stall pair into one effective action.
  function automatic stage_act_e resolve_action(
    input logic bubble,
    input logic stall,
    input logic bubble_wins
  );
    stage_act_e act;
    if (bubble && stall) begin
      act = bubble_wins ? ACT_BUBBLE : ACT_STALL;
    end else if (bubble) begin
      act = ACT_BUBBLE;
    end else if (stall) begin
      act = ACT_STALL;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter with synchronous clear.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset (q -> 0)
//   clr    in  1  synchronous clear, wins over inc
//   inc    in  1  count one event on this edge
//   q      out W  count, holds at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register placed between two adjacent stages.
// Each edge it loads, holds (stall) or inserts a nop image (bubble); it also
// keeps saturating stall/bubble counters and a sticky long-stall watchdog.
//   clk              in  1       rising-edge clock
//   rst_n            in  1       asynchronous active-low reset
//   bubble_i         in  1       insert a nop on the next edge
//   stall_i          in  1       hold current contents
//   valid_i          in  1       upstream payload is meaningful
//   data_i           in  DATA_W  upstream payload
//   clr_stats_i      in  1       synchronous clear of counters and timeout
//   data_o           out DATA_W  registered payload
//   valid_o          out 1       registered payload is a real instruction
//   stall_cnt_o      out CNT_W   effective-stall cycles, saturating
//   bubble_cnt_o     out CNT_W   effective-bubble cycles, saturating
//   stall_timeout_o  out 1       sticky: MAX_STALL consecutive stalls seen
// MAX_STALL must lie in 1 .. 2^CNT_W-1 so the run counter can reach it.
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import y86_pipe_pkg::*;
#(
  parameter int               DATA_W      = D_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL =
    {STAT_AOK, ICODE_NOP, {(DATA_W-STAT_W-ICODE_W){1'b0}}},
  parameter logic [DATA_W-1:0] RESET_VAL  = BUBBLE_VAL,
  parameter bit               BUBBLE_WINS = 1'b1,
  parameter int               CNT_W       = 16,
  parameter int               MAX_STALL   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_i,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_stats_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic              stall_timeout_o
);

  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(MAX_STALL);

  // -------------------------------------------------------------------------
  // Action resolution
  // -------------------------------------------------------------------------
  stage_act_e act;
  logic       do_stall;
  logic       do_bubble;

  assign act       = resolve_action(bubble_i, stall_i, BUBBLE_WINS);
  assign do_stall  = (act == ACT_STALL);
  assign do_bubble = (act == ACT_BUBBLE);

  // -------------------------------------------------------------------------
  // Payload and valid flag
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (act)
      ACT_LOAD: begin
        data_d  = data_i;
        valid_d = valid_i;
      end
      ACT_BUBBLE: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
      default: begin
        // stall: hold
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Event counters
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats_i),
    .inc   (do_stall),
    .q     (stall_cnt_q)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats_i),
    .inc   (do_bubble),
    .q     (bubble_cnt_q)
  );

  // -------------------------------------------------------------------------
  // Long-stall watchdog
  // run_q counts the current stall run and parks at MAX_RUN; the flag is set
  // from run_d so it rises on the very edge that completes the run.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_d;
  logic             timeout_q;
  logic             timeout_d;

  always_comb begin
    run_d     = run_q;
    timeout_d = timeout_q;
    if (clr_stats_i) begin
      run_d     = '0;
      timeout_d = 1'b0;
    end else if (do_stall) begin
      run_d     = (run_q == MAX_RUN) ? run_q : run_q + 1'b1;
      timeout_d = timeout_q | (run_d == MAX_RUN);
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign bubble_cnt_o    = bubble_cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances driven by identical stimulus: instance 0 lets a bubble win
// over a stall, instance 1 lets a stall win. A reference model computes the
// expected outputs per instance and pushes them to a scoreboard queue; a
// monitor pops and compares one entry per clock edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int MS = 4;
  localparam int SAT = 15;                     // all-ones for a 4-bit counter
  // nop image for a 16-bit payload: stat AOK (3'b001), icode NOP (4'h1), zeros
  localparam logic [DW-1:0] BUB = 16'h2200;
  localparam logic [DW-1:0] RST = 16'h00A5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bubble_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] data_i = '0;

  logic [DW-1:0] data_o  [2];
  logic          valid_o [2];
  logic [CW-1:0] scnt_o  [2];
  logic [CW-1:0] bcnt_o  [2];
  logic          to_o    [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pipe_stage_reg #(
      .DATA_W      (DW),
      .RESET_VAL   (RST),
      .BUBBLE_WINS (gi == 0),
      .CNT_W       (CW),
      .MAX_STALL   (MS)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bubble_i        (bubble_i),
      .stall_i         (stall_i),
      .valid_i         (valid_i),
      .data_i          (data_i),
      .clr_stats_i     (clr_i),
      .data_o          (data_o[gi]),
      .valid_o         (valid_o[gi]),
      .stall_cnt_o     (scnt_o[gi]),
      .bubble_cnt_o    (bcnt_o[gi]),
      .stall_timeout_o (to_o[gi])
    );
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    bit            valid;
    int            scnt;
    int            bcnt;
    bit            to;
  } exp_t;

  logic [DW-1:0] m_data  [2];
  bit            m_valid [2];
  int            m_scnt  [2];
  int            m_bcnt  [2];
  int            m_run   [2];
  bit            m_to    [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t",
               name, k, act, exp, $time);
    end
  endtask

  task automatic compare(input int k, input exp_t e);
    check("data_o", k, 32'(data_o[k]), 32'(e.data));
    check("valid_o", k, 32'(valid_o[k]), 32'(e.valid));
    check("stall_cnt_o", k, 32'(scnt_o[k]), 32'(e.scnt));
    check("bubble_cnt_o", k, 32'(bcnt_o[k]), 32'(e.bcnt));
    check("stall_timeout_o", k, 32'(to_o[k]), 32'(e.to));
  endtask

  function automatic exp_t snapshot(input int k);
    exp_t e;
    e.data  = m_data[k];
    e.valid = m_valid[k];
    e.scnt  = m_scnt[k];
    e.bcnt  = m_bcnt[k];
    e.to    = m_to[k];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k]  = RST;
      m_valid[k] = 1'b0;
      m_scnt[k]  = 0;
      m_bcnt[k]  = 0;
      m_run[k]   = 0;
      m_to[k]    = 1'b0;
    end
  endtask

  // Called at a falling edge: drive one cycle, predict, wait for next fall.
  task automatic step(input bit b, input bit s, input bit v,
                      input logic [DW-1:0] d, input bit c);
    bubble_i = b;
    stall_i  = s;
    valid_i  = v;
    data_i   = d;
    clr_i    = c;
    for (int k = 0; k < 2; k++) begin
      bit eff_b;
      bit eff_s;
      eff_b = b && (!s || (k == 0));
      eff_s = s && !eff_b;
      if (eff_b) begin
        m_data[k]  = BUB;
        m_valid[k] = 1'b0;
      end else if (!eff_s) begin
        m_data[k]  = d;
        m_valid[k] = v;
      end
      if (c) begin
        m_scnt[k] = 0;
        m_bcnt[k] = 0;
        m_run[k]  = 0;
        m_to[k]   = 1'b0;
      end else begin
        if (eff_s) m_scnt[k] = (m_scnt[k] < SAT) ? m_scnt[k] + 1 : SAT;
        if (eff_b) m_bcnt[k] = (m_bcnt[k] < SAT) ? m_bcnt[k] + 1 : SAT;
        if (eff_s) begin
          m_run[k] = (m_run[k] < MS) ? m_run[k] + 1 : MS;
          if (m_run[k] == MS) m_to[k] = 1'b1;
        end else begin
          m_run[k] = 0;
        end
      end
      if (k == 0) sb0.push_back(snapshot(k));
      else        sb1.push_back(snapshot(k));
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; checked before any edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) compare(k, snapshot(k));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) compare(0, sb0.pop_front());
      if (sb1.size() > 0) compare(1, sb1.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    apply_reset();

    // load then three stalls with changing data
    step(0, 0, 1, 16'h1234, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1'($urandom), 16'($urandom), 0);

    // bubble and stall together
    step(1, 1, 1, 16'($urandom), 0);
    step(1, 1, 1, 16'($urandom), 0);

    // watchdog: 3 stalls, 1 free, 4 stalls, then free cycles, then clear
    step(0, 0, 1, 16'h0BEE, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'($urandom), 0);
    step(0, 0, 1, 16'h0C0C, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 16'($urandom), 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 16'($urandom), 0);
    step(0, 0, 0, 16'($urandom), 1);

    // bubble counter saturation, then stall right after bubbles
    for (int i = 0; i < 20; i++) step(1, 0, 1, 16'($urandom), 0);
    step(0, 1, 1, 16'($urandom), 0);
    step(1, 1, 1, 16'($urandom), 0);

    // clear in the same cycle as a stall
    step(0, 0, 1, 16'h5A5A, 0);
    step(0, 1, 1, 16'($urandom), 0);
    step(0, 1, 1, 16'($urandom), 1);

    // reset mid-stream with 0x..AB held
    step(0, 0, 1, 16'h12AB, 0);
    step(0, 1, 1, 16'($urandom), 0);
    apply_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        apply_reset();
      end else begin
        step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60),
             1'($urandom), 16'($urandom), ($urandom_range(0, 99) < 3));
      end
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
               sb0.size(), sb1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got time %0t expected completion", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the per-stage F/D/E/M/W latches into one block. The stage payload is a single flat vector; per-stage field layouts live in the shared package. Adds:
- an asynchronous active-low reset;
- configurable bubble and reset images, and configurable bubble/stall priority;
- a valid flag;
- saturating stall and bubble event counters;
- a sticky watchdog that flags stalls lasting too long.

One instance sits between each pair of adjacent pipeline stages and is driven by the pipeline control logic.

## Interface
Parameters:
- DATA_W, 147: payload width. The default is the decode-stage bundle: stat 3, icode 4, ifun 4, rA 4, rB 4, valC 64, valP 64.
- BUBBLE_VAL, {STAT_AOK, ICODE_NOP, 0…}: payload loaded on a bubble.
- RESET_VAL, BUBBLE_VAL: payload after reset.
- BUBBLE_WINS, 1: 1 means a bubble overrides a stall; 0 means a stall overrides a bubble.
- CNT_W, 16: width of each event counter.
- MAX_STALL, 64: consecutive effective-stall cycles that trip the watchdog. Legal range is 1 to 2^CNT_W−1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- bubble_i  in  1  insert a nop on the next edge.
- stall_i  in  1  hold the current contents.
- valid_i  in  1  upstream payload is meaningful.
- data_i  in  DATA_W  upstream payload.
- clr_stats_i  in  1  synchronous clear of both counters and the timeout flag.
- data_o  out  DATA_W  registered payload.
- valid_o  out  1  registered payload holds a real instruction.
- stall_cnt_o  out  CNT_W  total effective-stall cycles, saturating.
- bubble_cnt_o  out  CNT_W  total effective-bubble cycles, saturating.
- stall_timeout_o  out  1  sticky watchdog flag.

## Operation
- Effective actions are resolved combinationally each cycle:
  - if bubble_i and stall_i are both high, BUBBLE_WINS selects the winner;
  - otherwise the asserted input acts;
  - with neither asserted, the stage loads.
- Load: data_o ← data_i, valid_o ← valid_i.
- Bubble: data_o ← BUBBLE_VAL, valid_o ← 0.
- Stall: data_o and valid_o hold.
- Stall counter: increments on each effective stall, holds at all-ones.
- Bubble counter: increments on each effective bubble, holds at all-ones.
- Watchdog:
  - the internal run counter increments on each consecutive effective stall and resets to 0 on any non-stall cycle;
  - when the run counter reaches MAX_STALL, stall_timeout_o sets;
  - stall_timeout_o stays set until clr_stats_i or reset, even after the stall ends;
  - the run counter saturates at MAX_STALL.
- clr_stats_i:
  - zeroes stall_cnt_o, bubble_cnt_o, the run counter and stall_timeout_o on the next edge;
  - it takes priority over increments in that same cycle, so the event in that cycle is not counted;
  - it has no effect on data_o or valid_o.
- Reset (rst_n low, at any time including mid-stall):
  - immediately sets data_o = RESET_VAL and valid_o = 0;
  - immediately sets both counters, the run counter and stall_timeout_o to 0.
- Reset release: the first rising edge with rst_n high performs a normal action. Stage control must deassert rst_n synchronously to clk.

## Timing
- Latency is 1 cycle from data_i/valid_i to data_o/valid_o on a load.
- All outputs are registered, with no combinational input→output path.
- A stall or bubble takes effect on the same edge at which it is sampled.
- Counters reflect events up to and including the previous edge.
- stall_timeout_o rises on the edge that completes the MAX_STALL-th consecutive stall cycle.
- Back-to-back bubbles keep the nop image and count once per cycle.
- A stall directly after a bubble holds the nop image with valid_o = 0.

## Structure
- Shared package y86_pipe_pkg holds:
  - STAT_W, ICODE_W, REG_W, WORD_W;
  - STAT_AOK/ADR/INS/HLT;
  - ICODE_NOP and ICODE_HALT;
  - per-stage payload widths D_W, E_W, M_W, W_W;
  - per-stage bubble images.
- Sub-module sat_counter, parameter W, with ports clk, rst_n, clr, inc, q. It is instantiated twice, for the stall and bubble counters. The watchdog run counter is inline logic.

## Test plan
- Reset behaviour: drive rst_n low mid-stream with data_o = 0x…AB. Required: data_o = RESET_VAL, valid_o = 0 and all counters 0 asynchronously, before the next clk edge.
- Load and stall: load 0x1234 with valid_i = 1, then hold stall_i high for 3 cycles while data_i changes. Required: data_o stays 0x1234, valid_o stays 1, stall_cnt_o = 3.
- Priority: assert bubble_i and stall_i together.
  - BUBBLE_WINS = 1: data_o = BUBBLE_VAL, valid_o = 0, bubble_cnt_o +1, stall_cnt_o unchanged.
  - BUBBLE_WINS = 0: contents hold, stall_cnt_o +1.
- Watchdog: with MAX_STALL = 4, apply a 3-cycle stall, 1 free cycle, then a 4-cycle stall. Required: stall_timeout_o stays 0 after the first run, rises on the 4th edge of the second run, and stays 1 afterwards. Then pulse clr_stats_i: stall_timeout_o = 0 and both counters = 0.
- Saturation: with CNT_W = 4, apply 20 consecutive bubbles. Required: bubble_cnt_o = 15 and holds there.
- Clear-versus-event: assert clr_stats_i and stall_i together. Required: stall_cnt_o = 0 after the edge, not 1, while data_o holds.
